// File: rtl/stack_unit_pkg.sv
// Shared constants for the stack-access sequencer: stage encodings, SP reset value
// and the op-priority decode.
package stack_unit_pkg;

  localparam int STAGE_COUNT = 5;

  localparam logic [STAGE_COUNT-1:0] STAGE_IF  = 5'b00001;
  localparam logic [STAGE_COUNT-1:0] STAGE_ID  = 5'b00010;
  localparam logic [STAGE_COUNT-1:0] STAGE_EX  = 5'b00100;
  localparam logic [STAGE_COUNT-1:0] STAGE_MEM = 5'b01000;
  localparam logic [STAGE_COUNT-1:0] STAGE_WB  = 5'b10000;

  localparam logic [7:0] SP_RESET_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_RCALL,
    OP_RET,
    OP_PUSH,
    OP_POP
  } op_e;

  // Flags are nominally one-hot; when several are high, rcall > ret > push > pop.
  function automatic op_e select_op(input logic rcall, input logic ret,
                                    input logic push, input logic pop);
    if (rcall)     return OP_RCALL;
    else if (ret)  return OP_RET;
    else if (push) return OP_PUSH;
    else if (pop)  return OP_POP;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_unit_stack_pointer.sv
// Stack-pointer register with inc/dec enables, the sp+1 read address and
// empty/full detection used for underflow/overflow.
module stack_pointer
  import stack_unit_pkg::*;
#(
  parameter int                  SP_WIDTH = 8,
  parameter logic [SP_WIDTH-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  output logic [SP_WIDTH-1:0] sp,
  output logic [SP_WIDTH-1:0] sp_plus1,
  output logic                at_bottom,
  output logic                at_top
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   sp <= SP_RESET;
    else if (dec) sp <= sp - SP_WIDTH'(1);
    else if (inc) sp <= sp + SP_WIDTH'(1);
  end

  assign sp_plus1  = sp + SP_WIDTH'(1);
  assign at_bottom = (sp == '0);
  assign at_top    = (sp == SP_RESET);

endmodule

// File: rtl/stack_unit.sv
// Stack-access sequencer: drives data memory during MEM for RCALL/RET/PUSH/POP,
// owns SP and returns the popped PC / data to writeback.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int                  SP_WIDTH = 8,
  parameter int                  PC_WIDTH = 10,
  parameter logic [SP_WIDTH-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_COUNT-1:0] pipeline_stage,
  input  logic                   cycle_count,
  input  logic                   op_rcall,
  input  logic                   op_ret,
  input  logic                   op_push,
  input  logic                   op_pop,
  input  logic [PC_WIDTH-1:0]    call_return_pc,
  input  logic [7:0]             push_data,
  input  logic [7:0]             mem_rdata,
  output logic [SP_WIDTH-1:0]    mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [SP_WIDTH-1:0]    sp,
  output logic [PC_WIDTH-1:0]    ret_pc,
  output logic                   ret_pc_valid,
  output logic [7:0]             pop_data,
  output logic                   pop_valid,
  output logic                   stack_err
);

  if (PC_WIDTH < 9 || PC_WIDTH > 16) begin : g_bad_pc_width
    $error("stack_unit: PC_WIDTH must be 9..16");
  end

  localparam int HI_WIDTH = PC_WIDTH - 8;

  op_e                  op;
  logic                 in_mem;
  logic                 in_wb;
  logic                 wr_access;
  logic                 rd_access;
  logic                 overflow;
  logic                 underflow;
  logic                 sp_inc;
  logic                 sp_dec;
  logic [SP_WIDTH-1:0]  sp_plus1;
  logic                 at_bottom;
  logic                 at_top;
  logic [7:0]           hi_byte;
  logic [7:0]           rd_byte;
  logic [HI_WIDTH-1:0]  hi_latch;

  stack_pointer #(
    .SP_WIDTH (SP_WIDTH),
    .SP_RESET (SP_RESET)
  ) u_stack_pointer (
    .clk       (clk),
    .reset     (reset),
    .inc       (sp_inc),
    .dec       (sp_dec),
    .sp        (sp),
    .sp_plus1  (sp_plus1),
    .at_bottom (at_bottom),
    .at_top    (at_top)
  );

  // Gating with reset keeps every strobe idle while reset is held.
  always_comb begin
    op        = select_op(op_rcall, op_ret, op_push, op_pop);
    in_mem    = reset && (pipeline_stage == STAGE_MEM);
    in_wb     = reset && (pipeline_stage == STAGE_WB);
    wr_access = in_mem && (op == OP_RCALL || op == OP_PUSH);
    rd_access = in_mem && (op == OP_RET || op == OP_POP);
    overflow  = wr_access && at_bottom;
    underflow = rd_access && at_top;
    mem_we    = wr_access && !at_bottom;
    mem_re    = rd_access && !at_top;
    sp_dec    = mem_we;
    sp_inc    = mem_re;
    rd_byte   = underflow ? 8'h00 : mem_rdata;

    hi_byte = '0;
    hi_byte[HI_WIDTH-1:0] = call_return_pc[PC_WIDTH-1:8];

    mem_addr  = rd_access ? sp_plus1 : sp;
    mem_wdata = '0;
    if (wr_access) begin
      if (op == OP_PUSH)   mem_wdata = push_data;
      else if (cycle_count) mem_wdata = hi_byte;
      else                  mem_wdata = call_return_pc[7:0];
    end

    ret_pc_valid = in_wb && (op == OP_RET);
    pop_valid    = in_wb && (op == OP_POP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_latch  <= '0;
      ret_pc    <= '0;
      pop_data  <= '0;
      stack_err <= 1'b0;
    end else begin
      if (in_mem && op == OP_RET) begin
        if (!cycle_count) hi_latch <= rd_byte[HI_WIDTH-1:0];
        else              ret_pc   <= {hi_latch, rd_byte};
      end
      if (in_mem && op == OP_POP) pop_data <= rd_byte;
      if (overflow || underflow) stack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit with a 256-byte data-memory model.
module tb_stack_unit;
  import stack_unit_pkg::*;

  logic                   clk;
  logic                   reset;
  logic [STAGE_COUNT-1:0] pipeline_stage;
  logic                   cycle_count;
  logic                   op_rcall, op_ret, op_push, op_pop;
  logic [9:0]             call_return_pc;
  logic [7:0]             push_data;
  logic [7:0]             mem_rdata;
  logic [7:0]             mem_addr;
  logic [7:0]             mem_wdata;
  logic                   mem_we, mem_re;
  logic [7:0]             sp;
  logic [9:0]             ret_pc;
  logic                   ret_pc_valid;
  logic [7:0]             pop_data;
  logic                   pop_valid;
  logic                   stack_err;

  logic [7:0] mem [256];
  logic       mem_clr;
  int         checks = 0;
  int         fails  = 0;

  stack_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pipeline_stage (pipeline_stage),
    .cycle_count    (cycle_count),
    .op_rcall       (op_rcall),
    .op_ret         (op_ret),
    .op_push        (op_push),
    .op_pop         (op_pop),
    .call_return_pc (call_return_pc),
    .push_data      (push_data),
    .mem_rdata      (mem_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .sp             (sp),
    .ret_pc         (ret_pc),
    .ret_pc_valid   (ret_pc_valid),
    .pop_data       (pop_data),
    .pop_valid      (pop_valid),
    .stack_err      (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic drive(input logic [STAGE_COUNT-1:0] st, input logic cc);
    pipeline_stage = st;
    cycle_count    = cc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic rc, input logic rt, input logic ps, input logic pp);
    op_rcall = rc;
    op_ret   = rt;
    op_push  = ps;
    op_pop   = pp;
  endtask

  initial begin
    reset          = 1'b0;
    mem_clr        = 1'b1;
    call_return_pc = '0;
    push_data      = '0;
    set_ops(0, 1, 0, 0);
    drive(STAGE_MEM, 1'b0);
    tick;
    tick;

    // Reset held in the middle of RET cycle 0
    check("rst_sp", 16'(sp), 16'hFF);
    check("rst_ret_pc", 16'(ret_pc), 16'h0);
    check("rst_err", 16'(stack_err), 16'h0);
    check("rst_we", 16'(mem_we), 16'h0);
    check("rst_re", 16'(mem_re), 16'h0);
    check("rst_addr", 16'(mem_addr), 16'hFF);
    check("rst_valid", 16'(ret_pc_valid), 16'h0);

    set_ops(0, 0, 0, 0);
    drive(STAGE_IF, 1'b0);
    mem_clr = 1'b0;
    reset   = 1'b1;
    tick;

    // RCALL 0x2A5 from sp=FF
    set_ops(1, 0, 0, 0);
    call_return_pc = 10'h2A5;
    drive(STAGE_ID, 1'b0);  tick;
    drive(STAGE_EX, 1'b0);  tick;
    drive(STAGE_MEM, 1'b0);
    check("rcall0_we", 16'(mem_we), 16'h1);
    check("rcall0_addr", 16'(mem_addr), 16'hFF);
    check("rcall0_wdata", 16'(mem_wdata), 16'hA5);
    tick;
    drive(STAGE_MEM, 1'b1);
    check("rcall1_sp", 16'(sp), 16'hFE);
    check("rcall1_we", 16'(mem_we), 16'h1);
    check("rcall1_addr", 16'(mem_addr), 16'hFE);
    check("rcall1_wdata", 16'(mem_wdata), 16'h02);
    tick;
    drive(STAGE_WB, 1'b0);
    check("rcall_sp", 16'(sp), 16'hFD);
    check("rcall_mem_ff", 16'(mem[8'hFF]), 16'hA5);
    check("rcall_mem_fe", 16'(mem[8'hFE]), 16'h02);
    check("rcall_wb_valid", 16'(ret_pc_valid), 16'h0);
    tick;

    // RET round trip
    set_ops(0, 1, 0, 0);
    drive(STAGE_ID, 1'b0);  tick;
    drive(STAGE_MEM, 1'b0);
    check("ret0_re", 16'(mem_re), 16'h1);
    check("ret0_we", 16'(mem_we), 16'h0);
    check("ret0_addr", 16'(mem_addr), 16'hFE);
    tick;
    drive(STAGE_MEM, 1'b1);
    check("ret1_re", 16'(mem_re), 16'h1);
    check("ret1_addr", 16'(mem_addr), 16'hFF);
    tick;
    drive(STAGE_WB, 1'b0);
    check("ret_sp", 16'(sp), 16'hFF);
    check("ret_pc", 16'(ret_pc), 16'h2A5);
    check("ret_valid_wb", 16'(ret_pc_valid), 16'h1);
    tick;
    drive(STAGE_IF, 1'b0);
    check("ret_valid_after", 16'(ret_pc_valid), 16'h0);
    tick;

    // PUSH 3C then POP
    set_ops(0, 0, 1, 0);
    push_data = 8'h3C;
    drive(STAGE_MEM, 1'b1);
    check("push_we", 16'(mem_we), 16'h1);
    check("push_addr", 16'(mem_addr), 16'hFF);
    check("push_wdata", 16'(mem_wdata), 16'h3C);
    tick;
    drive(STAGE_WB, 1'b0);
    check("push_sp", 16'(sp), 16'hFE);
    check("push_mem", 16'(mem[8'hFF]), 16'h3C);
    check("push_pop_valid", 16'(pop_valid), 16'h0);
    tick;
    set_ops(0, 0, 0, 1);
    drive(STAGE_MEM, 1'b0);
    check("pop_re", 16'(mem_re), 16'h1);
    check("pop_addr", 16'(mem_addr), 16'hFF);
    tick;
    drive(STAGE_WB, 1'b0);
    check("pop_data", 16'(pop_data), 16'h3C);
    check("pop_valid_wb", 16'(pop_valid), 16'h1);
    check("pop_sp", 16'(sp), 16'hFF);
    check("pop_err", 16'(stack_err), 16'h0);
    tick;
    drive(STAGE_IF, 1'b0);
    check("pop_valid_after", 16'(pop_valid), 16'h0);
    tick;

    // Underflow: POP on empty stack
    drive(STAGE_MEM, 1'b0);
    check("uflow_re", 16'(mem_re), 16'h0);
    tick;
    drive(STAGE_WB, 1'b0);
    check("uflow_sp", 16'(sp), 16'hFF);
    check("uflow_err", 16'(stack_err), 16'h1);
    tick;

    // Priority: push wins over pop; error stays sticky through legal ops
    set_ops(0, 0, 1, 1);
    push_data = 8'h55;
    drive(STAGE_MEM, 1'b0);
    check("prio_we", 16'(mem_we), 16'h1);
    check("prio_re", 16'(mem_re), 16'h0);
    check("prio_wdata", 16'(mem_wdata), 16'h55);
    tick;
    set_ops(0, 0, 0, 1);
    drive(STAGE_MEM, 1'b0);
    check("sticky_sp_mid", 16'(sp), 16'hFE);
    tick;
    drive(STAGE_WB, 1'b0);
    check("sticky_pop_data", 16'(pop_data), 16'h55);
    check("sticky_sp", 16'(sp), 16'hFF);
    check("sticky_err", 16'(stack_err), 16'h1);
    tick;

    // Reset clears the error
    reset = 1'b0;
    #1;
    check("rst2_err", 16'(stack_err), 16'h0);
    check("rst2_sp", 16'(sp), 16'hFF);
    tick;
    reset = 1'b1;
    drive(STAGE_IF, 1'b0);
    tick;

    // Overflow: fill down to sp=1, then RCALL
    set_ops(0, 0, 1, 0);
    push_data = 8'h11;
    drive(STAGE_MEM, 1'b0);
    for (int i = 0; i < 254; i++) tick;
    drive(STAGE_IF, 1'b0);
    check("fill_sp", 16'(sp), 16'h01);
    check("fill_err", 16'(stack_err), 16'h0);
    tick;
    set_ops(1, 0, 0, 0);
    call_return_pc = 10'h1C3;
    drive(STAGE_MEM, 1'b0);
    check("oflow0_we", 16'(mem_we), 16'h1);
    check("oflow0_addr", 16'(mem_addr), 16'h01);
    tick;
    drive(STAGE_MEM, 1'b1);
    check("oflow1_sp", 16'(sp), 16'h00);
    check("oflow1_we", 16'(mem_we), 16'h0);
    tick;
    drive(STAGE_WB, 1'b0);
    check("oflow_sp", 16'(sp), 16'h00);
    check("oflow_err", 16'(stack_err), 16'h1);
    check("oflow_mem01", 16'(mem[8'h01]), 16'hC3);
    check("oflow_mem00", 16'(mem[8'h00]), 16'h00);
    tick;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
